branch_update_gen: RTL and testbench

- Producer side of the `branch_update_t` interface that feeds the local, global and tournament predictors.
- Records each prediction issued at fetch in an in-order queue.
- Pairs each record with its execute-stage resolution, then drives one registered `branch_update_t` per resolved branch, plus a mispredict flag for the pipeline.
- Sits between the fetch/predict stage and the predictor update port.

---
 rtl/riscv_types_pkg.sv | 22 ++
 rtl/bu_rec_fifo.sv | 72 +++++++
 rtl/branch_update_gen.sv | 116 +++++++++++
 tb/tb_branch_update_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_types_pkg.sv
// Shared RISC-V front-end types: PC type, predictor update bundle, and the
// in-flight prediction record used by branch_update_gen.
package riscv_types_pkg;

  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic  update_valid;
    addr_t update_pc;
    logic  is_branch;
    logic  actual_taken;
  } branch_update_t;

  typedef struct packed {
    addr_t pc;
    logic  is_branch;
    logic  pred_taken;
  } bu_rec_t;

  localparam int unsigned BU_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/bu_rec_fifo.sv
// Circular buffer of prediction records with push, pop and clear.
// Clear overrides push; a pop in the clear cycle still sees its head entry.
module bu_rec_fifo
  import riscv_types_pkg::*;
#(
  parameter int unsigned DEPTH = BU_DEPTH_DEFAULT,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  bu_rec_t       push_data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output bu_rec_t       pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  bu_rec_t       mem_q [DEPTH];
  bu_rec_t       mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign pop_data_o = mem_q[rd_q];

  // No bypass: a full queue refuses a push even when a pop happens this cycle.
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = wr_q + PW'(1);
      end
      if (pop_ok) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_update_gen.sv
// Pairs fetch-time predictions with execute resolutions and drives one
// registered predictor update per resolve. Optional counters: BRANCH_UPDATE_STATS_EN.
module branch_update_gen
  import riscv_types_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = BU_DEPTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rec_valid_i,
  output logic                  rec_ready_o,
  input  logic [ADDR_WIDTH-1:0] rec_pc_i,
  input  logic                  rec_is_branch_i,
  input  logic                  rec_pred_taken_i,
  input  logic                  res_valid_i,
  input  logic                  res_taken_i,
  input  logic                  flush_i,
  output branch_update_t        update_o,
  output logic                  mispredict_o,
  output logic                  proto_err_o,
  output logic [31:0]           stat_resolved_o,
  output logic [31:0]           stat_mispred_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  bu_rec_t        rec_in, head;
  logic           fifo_full, fifo_empty, pop;
  logic [CW-1:0]  fifo_count;
  branch_update_t upd_q, upd_d;
  logic           misp_q, misp_d, err_q, err_d;

  assign rec_in.pc         = addr_t'(rec_pc_i);
  assign rec_in.is_branch  = rec_is_branch_i;
  assign rec_in.pred_taken = rec_pred_taken_i;
  assign pop               = res_valid_i && !fifo_empty;

  bu_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (rec_valid_i),
    .push_data_i (rec_in),
    .pop_i       (pop),
    .clear_i     (flush_i),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rec_ready_o = !fifo_full;

  // Payload fields hold between updates; only valid/mispredict pulse.
  always_comb begin
    upd_d              = upd_q;
    upd_d.update_valid = 1'b0;
    misp_d             = 1'b0;
    err_d              = err_q;
    if (pop) begin
      upd_d.update_valid = 1'b1;
      upd_d.update_pc    = head.pc;
      upd_d.is_branch    = head.is_branch;
      upd_d.actual_taken = res_taken_i;
      misp_d             = (head.pred_taken != res_taken_i);
    end
    if (res_valid_i && (fifo_count == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      upd_q  <= '0;
      misp_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      upd_q  <= upd_d;
      misp_q <= misp_d;
      err_q  <= err_d;
    end
  end

  assign update_o     = upd_q;
  assign mispredict_o = misp_q;
  assign proto_err_o  = err_q;

`ifdef BRANCH_UPDATE_STATS_EN
  logic [31:0] resolved_q, resolved_d, mispred_q, mispred_d;

  // Only conditional branches count; jumps are emitted but not tallied.
  always_comb begin
    resolved_d = resolved_q;
    mispred_d  = mispred_q;
    if (pop && head.is_branch) begin
      if (resolved_q != '1) resolved_d = resolved_q + 32'd1;
      if (misp_d && (mispred_q != '1)) mispred_d = mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      resolved_q <= resolved_d;
      mispred_q  <= mispred_d;
    end
  end

  assign stat_resolved_o = resolved_q;
  assign stat_mispred_o  = mispred_q;
`else
  assign stat_resolved_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_update_gen.sv
// Scoreboard bench for branch_update_gen: a queue-based model predicts each
// update; a monitor compares every cycle one time unit after the edge.
module tb_branch_update_gen;
  import riscv_types_pkg::*;

  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           rec_valid_i = 1'b0, rec_ready_o;
  logic [31:0]    rec_pc_i = '0;
  logic           rec_is_branch_i = 1'b0, rec_pred_taken_i = 1'b0;
  logic           res_valid_i = 1'b0, res_taken_i = 1'b0, flush_i = 1'b0;
  branch_update_t update_o;
  logic           mispredict_o, proto_err_o;
  logic [31:0]    stat_resolved_o, stat_mispred_o;

  always #5 clk = ~clk;

  branch_update_gen #(.ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .rec_valid_i      (rec_valid_i),
    .rec_ready_o      (rec_ready_o),
    .rec_pc_i         (rec_pc_i),
    .rec_is_branch_i  (rec_is_branch_i),
    .rec_pred_taken_i (rec_pred_taken_i),
    .res_valid_i      (res_valid_i),
    .res_taken_i      (res_taken_i),
    .flush_i          (flush_i),
    .update_o         (update_o),
    .mispredict_o     (mispredict_o),
    .proto_err_o      (proto_err_o),
    .stat_resolved_o  (stat_resolved_o),
    .stat_mispred_o   (stat_mispred_o)
  );

  typedef struct {logic [31:0] pc; logic br; logic pred;} rec_s;
  typedef struct {logic [31:0] pc; logic br; logic act; logic misp;} upd_s;

  rec_s        mq[$];      // outstanding predictions, oldest first
  upd_s        exp_q[$];   // updates expected after the next edge
  logic        m_err = 1'b0;
  int unsigned m_res = 0, m_mis = 0;
  logic        last_rst = 1'b1;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, advance the model at the posedge.
  task automatic step(input logic rst, input logic pv, input logic [31:0] pc,
                      input logic br, input logic pr, input logic rv,
                      input logic rt, input logic fl);
    bit   can_push;
    rec_s r;
    upd_s u;
    @(negedge clk);
    rst_ni = rst; rec_valid_i = pv; rec_pc_i = pc; rec_is_branch_i = br;
    rec_pred_taken_i = pr; res_valid_i = rv; res_taken_i = rt; flush_i = fl;
    if (rst) chk("rec_ready", rec_ready_o, (mq.size() != DEPTH));
    @(posedge clk);
    last_rst = !rst;
    if (!rst) begin
      mq.delete(); exp_q.delete();
      m_err = 1'b0; m_res = 0; m_mis = 0;
    end else begin
      can_push = (mq.size() < DEPTH);
      if (rv) begin
        if (mq.size() == 0) m_err = 1'b1;
        else begin
          r = mq.pop_front();
          u.pc = r.pc; u.br = r.br; u.act = rt; u.misp = (r.pred != rt);
          exp_q.push_back(u);
          if (r.br) begin
            m_res++;
            if (u.misp) m_mis++;
          end
        end
      end
      if (pv && can_push && !fl) begin
        r.pc = pc; r.br = br; r.pred = pr;
        mq.push_back(r);
      end
      if (fl) mq.delete();
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic br, input logic pr);
    step(1, 1, pc, br, pr, 0, 0, 0);
  endtask

  task automatic resolve(input logic rt);
    step(1, 0, 32'h0, 0, 0, 1, rt, 0);
  endtask

  task automatic idle();
    step(1, 0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  // Monitor
  initial begin : monitor
    upd_s        u;
    logic [31:0] lpc;
    logic        lbr, lact;
    lpc = '0; lbr = 1'b0; lact = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (last_rst) begin
        chk("rst_update", update_o, '0);
        chk("rst_mispredict", mispredict_o, 0);
        lpc = '0; lbr = 1'b0; lact = 1'b0;
      end else if (update_o.update_valid) begin
        if (exp_q.size() == 0) chk("spurious_update", 1, 0);
        else begin
          u = exp_q.pop_front();
          chk("upd_pc", update_o.update_pc, u.pc);
          chk("upd_is_branch", update_o.is_branch, u.br);
          chk("upd_actual", update_o.actual_taken, u.act);
          chk("upd_mispredict", mispredict_o, u.misp);
          lpc = u.pc; lbr = u.br; lact = u.act;
        end
      end else begin
        chk("missing_update", exp_q.size(), 0);
        exp_q.delete();
        chk("idle_mispredict", mispredict_o, 0);
        chk("idle_pc_hold", update_o.update_pc, lpc);
        chk("idle_br_hold", update_o.is_branch, lbr);
        chk("idle_act_hold", update_o.actual_taken, lact);
      end
      chk("proto_err", proto_err_o, m_err);
`ifdef BRANCH_UPDATE_STATS_EN
      chk("stat_resolved", stat_resolved_o, m_res);
      chk("stat_mispred", stat_mispred_o, m_mis);
`else
      chk("stat_resolved", stat_resolved_o, 0);
      chk("stat_mispred", stat_mispred_o, 0);
`endif
    end
  end

  initial begin : driver
    logic rst, pv, rv, fl;
    do_reset(); do_reset();

    // Basic correct prediction, then a mispredict
    push(32'h100, 1, 1); resolve(1); idle();
    push(32'h200, 1, 0); resolve(1); idle();

    // Fill, push+resolve while full, wrap
    for (int i = 0; i < 8; i++) push(32'(i * 4), 1, i[0]);
    step(1, 1, 32'h99, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h40 + 32'(i * 4), i[1], 1, 1, i[0], 0);
    for (int i = 0; i < 9; i++) resolve(i[0]);
    idle();

    // Flush with concurrent resolve, then a resolve on empty
    push(32'h300, 1, 1); push(32'h304, 0, 0); push(32'h308, 1, 0);
    step(1, 0, 32'h0, 0, 0, 1, 0, 1);
    resolve(1); idle();

    // Push and resolve together on empty
    do_reset();
    step(1, 1, 32'h400, 1, 1, 1, 0, 0);
    resolve(1); idle();

    // Reset with records queued
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(i * 4), 1, 0);
    do_reset();
    idle(); resolve(1); idle();
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      pv  = ($urandom_range(0, 99) < 55);
      rv  = ($urandom_range(0, 99) < 45);
      fl  = ($urandom_range(0, 99) < 3);
      step(rst, pv, $urandom, 1'($urandom), 1'($urandom), rv, 1'($urandom), fl);
    end
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
